// File: rtl/isp8_bus_pkg.sv
// Shared definitions for the isp8 external-port bus masters.
// Contents: FSM state encoding, bus address-space select bit values and
// the data returned to the CPU when a read ends in error or timeout.
package isp8_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

    localparam logic       SPACE_IO    = 1'b0;
    localparam logic       SPACE_MEM   = 1'b1;
    localparam logic [7:0] RD_ERR_DATA = 8'hFF;

endpackage

// File: rtl/isp8_wb_timeout.sv
// Bus-cycle watchdog shared by the isp8 bus masters.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (wins over en)
//   en         : count this cycle; also qualifies expired
//   expired    : this is the TMO_CYC-th enabled cycle since clr
module isp8_wb_timeout #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // The count starts at 0 in the first enabled cycle, so matching
    // TMO_CYC-1 fires on exactly the TMO_CYC-th cycle.
    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/isp8_wb_bridge.sv
// Converts isp8 single-cycle external-port strobes into Wishbone-style
// 8-bit bus cycles and returns read data to the CPU.
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   ext_addr/ext_dout         : CPU address and write data
//   ext_io_wr/rd, ext_mem_wr/rd : one-cycle request strobes
//   ext_din, rd_valid         : read data and its one-cycle update pulse
//   cpu_stall                 : CPU hold request
//   wb_*                      : bus master side; adr MSB selects mem (1) / IO (0)
//   err_flag, err_clr         : sticky error/timeout/dropped-strobe flag and clear
module isp8_wb_bridge
    import isp8_bus_pkg::*;
#(
    parameter int PORT_AW = 8,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PORT_AW-1:0] ext_addr,
    input  logic [7:0]         ext_dout,
    input  logic               ext_io_wr,
    input  logic               ext_io_rd,
    input  logic               ext_mem_wr,
    input  logic               ext_mem_rd,
    output logic [7:0]         ext_din,
    output logic               rd_valid,
    output logic               cpu_stall,
    output logic [PORT_AW:0]   wb_adr_o,
    output logic [7:0]         wb_dat_o,
    output logic               wb_we_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    input  logic [7:0]         wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    output logic               err_flag,
    input  logic               err_clr
);

    bus_state_e       state_q, state_d;
    logic [PORT_AW:0] adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic [7:0]       din_q, din_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_flag_q, err_flag_d;

    logic any_stb, collision, sel_we, sel_space;
    logic err_set, term_err, tmo_clr, tmo_en, tmo_expired;

    // Fixed priority io_wr > io_rd > mem_wr > mem_rd.
    assign any_stb   = ext_io_wr | ext_io_rd | ext_mem_wr | ext_mem_rd;
    assign collision = (ext_io_wr & (ext_io_rd | ext_mem_wr | ext_mem_rd))
                     | (ext_io_rd & (ext_mem_wr | ext_mem_rd))
                     | (ext_mem_wr & ext_mem_rd);
    assign sel_space = (ext_io_wr | ext_io_rd) ? SPACE_IO : SPACE_MEM;
    assign sel_we    = ext_io_wr | (~ext_io_rd & ext_mem_wr);

    isp8_wb_timeout #(
        .TMO_W  (TMO_W),
        .TMO_CYC(TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    assign term_err = wb_err_i | tmo_expired;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        din_d      = din_q;
        rd_valid_d = 1'b0;
        err_set    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_stb) begin
                    state_d = ST_BUS;
                    adr_d   = {sel_space, ext_addr};
                    dat_d   = ext_dout;
                    we_d    = sel_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    tmo_clr = 1'b1;
                    err_set = collision;
                end
            end
            ST_BUS: begin
                tmo_en  = 1'b1;
                err_set = any_stb;   // CPU ignored the stall
                if (wb_ack_i || term_err) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rd_valid_d = 1'b1;
                        din_d      = term_err ? RD_ERR_DATA : wb_dat_i;
                    end
                    if (term_err) err_set = 1'b1;
                end
            end
            ST_DONE: begin
                err_set = any_stb;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new error in the same cycle as a clear must not be lost.
        err_flag_d = err_flag_q;
        if (err_set)      err_flag_d = 1'b1;
        else if (err_clr) err_flag_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            din_q      <= '0;
            rd_valid_q <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            din_q      <= din_d;
            rd_valid_q <= rd_valid_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Combinational term lets the CPU freeze in the same cycle it strobes.
    assign cpu_stall = (state_q != ST_IDLE) | any_stb;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign ext_din   = din_q;
    assign rd_valid  = rd_valid_q;
    assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_isp8_wb_bridge.sv
module tb_isp8_wb_bridge;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ext_addr, ext_dout, ext_din, wb_dat_o, wb_dat_i;
    logic       ext_io_wr, ext_io_rd, ext_mem_wr, ext_mem_rd;
    logic       rd_valid, cpu_stall, wb_we_o, wb_cyc_o, wb_stb_o;
    logic       wb_ack_i, wb_err_i, err_flag, err_clr;
    logic [8:0] wb_adr_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    isp8_wb_bridge #(.PORT_AW(8), .TMO_W(8), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_addr(ext_addr), .ext_dout(ext_dout),
        .ext_io_wr(ext_io_wr), .ext_io_rd(ext_io_rd),
        .ext_mem_wr(ext_mem_wr), .ext_mem_rd(ext_mem_rd),
        .ext_din(ext_din), .rd_valid(rd_valid), .cpu_stall(cpu_stall),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .err_flag(err_flag), .err_clr(err_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: expected read data pushed at strobe time, popped on rd_valid.
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_valid_unexpected got=1 exp=0");
            end else begin
                mon_exp = exp_q.pop_front();
                chk("ext_din", 32'(ext_din), 32'(mon_exp));
            end
        end
    end

    // kind: 0 io_wr, 1 io_rd, 2 mem_wr, 3 mem_rd; dly = BUS cycle that
    // terminates (0 = never, timeout expected)
    typedef struct {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [7:0] dout;
        logic [7:0] rdata;
        int         dly;
        logic       ack;
        logic       err;
        logic [8:0] exp_adr;
        logic       exp_we;
        logic [7:0] exp_din;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] r, input int dl, input logic ak, input logic er,
                                input logic [8:0] ea, input logic ew, input logic [7:0] ed,
                                input logic ee);
        vec_t v;
        v.kind = k; v.addr = a; v.dout = d; v.rdata = r; v.dly = dl; v.ack = ak; v.err = er;
        v.exp_adr = ea; v.exp_we = ew; v.exp_din = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        ext_io_wr = 0; ext_io_rd = 0; ext_mem_wr = 0; ext_mem_rd = 0;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int  bus_n, stall_n, idx, rv_cnt, rv_at, exp_bus;
        bit  done;
        bit  is_rd;
        is_rd   = !v.exp_we;
        exp_bus = (v.dly == 0) ? TMO : v.dly;
        ext_addr = v.addr; ext_dout = v.dout;
        ext_io_wr  = (v.kind == 2'd0);
        ext_io_rd  = (v.kind == 2'd1);
        ext_mem_wr = (v.kind == 2'd2);
        ext_mem_rd = (v.kind == 2'd3);
        if (is_rd) exp_q.push_back(v.exp_din);
        #1;
        chk({nm, "_stall0"}, 32'(cpu_stall), 32'd1);
        bus_n = 0; stall_n = 1; idx = 0; rv_cnt = 0; rv_at = -1; done = 0;
        for (int g = 0; g < 40; g++) begin
            step();
            clear_strobes();
            wb_ack_i = 0; wb_err_i = 0;
            idx++;
            if (rd_valid) begin rv_cnt++; rv_at = idx; end
            if (!cpu_stall) begin done = 1; break; end
            stall_n++;
            if (wb_cyc_o) begin
                bus_n++;
                if (bus_n == 1) begin
                    chk({nm, "_adr"}, 32'(wb_adr_o), 32'(v.exp_adr));
                    chk({nm, "_we"},  32'(wb_we_o),  32'(v.exp_we));
                    chk({nm, "_dat"}, 32'(wb_dat_o), 32'(v.dout));
                    chk({nm, "_stb"}, 32'(wb_stb_o), 32'd1);
                end
                if (bus_n == v.dly) begin
                    wb_ack_i = v.ack; wb_err_i = v.err; wb_dat_i = v.rdata;
                end
            end
        end
        chk({nm, "_finished"}, 32'(done), 32'd1);
        chk({nm, "_cyc_cycles"}, 32'(bus_n), 32'(exp_bus));
        chk({nm, "_stall_cycles"}, 32'(stall_n), 32'(exp_bus + 2));
        chk({nm, "_rv_count"}, 32'(rv_cnt), 32'(is_rd));
        if (is_rd) chk({nm, "_rv_at"}, 32'(rv_at), 32'(exp_bus + 1));
        chk({nm, "_err_flag"}, 32'(err_flag), 32'(v.exp_err));
        err_clr = 1;
        step();
        err_clr = 0;
        chk({nm, "_err_clr"}, 32'(err_flag), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(2'd0, 8'h12, 8'hA5, 8'h00, 2, 1, 0, 9'h012, 1, 8'h00, 0);
        vecs[1] = mk(2'd3, 8'h80, 8'h00, 8'h3C, 1, 1, 0, 9'h180, 0, 8'h3C, 0);
        vecs[2] = mk(2'd1, 8'h33, 8'h00, 8'h00, 0, 0, 0, 9'h033, 0, 8'hFF, 1);
        vecs[3] = mk(2'd1, 8'h44, 8'h00, 8'h55, 1, 1, 1, 9'h044, 0, 8'hFF, 1);
        vecs[4] = mk(2'd2, 8'hFE, 8'h5A, 8'h00, 3, 1, 0, 9'h1FE, 1, 8'h00, 0);
        vecs[5] = mk(2'd1, 8'h07, 8'h00, 8'h99, 3, 1, 0, 9'h007, 0, 8'h99, 0);
        vecs[6] = mk(2'd3, 8'h00, 8'h00, 8'hAB, 2, 0, 1, 9'h100, 0, 8'hFF, 1);
        vecs[7] = mk(2'd0, 8'hC3, 8'h3C, 8'h00, 1, 0, 1, 9'h0C3, 1, 8'h00, 1);

        rst_n = 0; clear_strobes();
        ext_addr = 0; ext_dout = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; err_clr = 0;
        step(); step();
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        rst_n = 1;
        step();

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Collision with err_clr in the same cycle, then a strobe during BUS.
        ext_addr = 8'h21; ext_dout = 8'h00; ext_io_rd = 1; ext_mem_wr = 1; err_clr = 1;
        exp_q.push_back(8'h77);
        step();
        clear_strobes(); err_clr = 0;
        chk("col_adr", 32'(wb_adr_o), 32'h021);
        chk("col_we", 32'(wb_we_o), 32'd0);
        chk("col_cyc", 32'(wb_cyc_o), 32'd1);
        chk("col_err_over_clr", 32'(err_flag), 32'd1);
        ext_addr = 8'h99; ext_dout = 8'h11; ext_mem_wr = 1;
        step();
        clear_strobes();
        chk("inj_adr", 32'(wb_adr_o), 32'h021);
        chk("inj_dat", 32'(wb_dat_o), 32'h00);
        wb_ack_i = 1; wb_dat_i = 8'h77;
        step();
        wb_ack_i = 0;
        chk("col_done_cyc", 32'(wb_cyc_o), 32'd0);
        chk("col_done_stall", 32'(cpu_stall), 32'd1);
        chk("col_done_rv", 32'(rd_valid), 32'd1);
        step();
        chk("col_idle_stall", 32'(cpu_stall), 32'd0);
        err_clr = 1; step(); err_clr = 0;

        // Reset while in BUS; a late ack must be ignored.
        ext_addr = 8'h10; ext_io_rd = 1; ext_mem_rd = 1;
        step();
        clear_strobes();
        chk("rm_bus_cyc", 32'(wb_cyc_o), 32'd1);
        chk("rm_err_pre", 32'(err_flag), 32'd1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("rm_adr", 32'(wb_adr_o), 32'd0);
        chk("rm_dat", 32'(wb_dat_o), 32'd0);
        chk("rm_din", 32'(ext_din), 32'd0);
        chk("rm_we", 32'(wb_we_o), 32'd0);
        chk("rm_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rm_stb", 32'(wb_stb_o), 32'd0);
        chk("rm_err", 32'(err_flag), 32'd0);
        chk("rm_rv", 32'(rd_valid), 32'd0);
        wb_ack_i = 1; wb_dat_i = 8'hEE;
        step();
        wb_ack_i = 0;
        chk("rm_late_rv", 32'(rd_valid), 32'd0);
        chk("rm_late_stall", 32'(cpu_stall), 32'd0);
        step();
        run_txn(vecs[1], "post_rst");

        step(); step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
